// File: rtl/mcpu_ram_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_ram_bist_if
// Description : RAM-controller port bundle between the BIST initiator (master)
//               and the RAM controller or its model (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mcpu_ram_bist_if #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  we;
    logic                  re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  datawr;
    logic [ADDR_WIDTH-1:0] instraddr;
    logic [WORD_SIZE-1:0]  datard;
    logic [WORD_SIZE-1:0]  instrrd;

    modport master (
        output we, re, addr, datawr, instraddr,
        input  datard, instrrd
    );

    modport slave (
        input  we, re, addr, datawr, instraddr,
        output datard, instrrd
    );
endinterface
`default_nettype wire

// File: rtl/mcpu_ram_bist.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_ram_bist
// Description : Fills the MCPU RAM with an LFSR pattern, reads it back through
//               the data and instruction ports and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu_ram_bist #(
    parameter int                   WORD_SIZE  = 16,
    parameter int                   ADDR_WIDTH = 8,
    parameter logic [WORD_SIZE-1:0] SEED       = 16'hACE1,
    parameter logic [WORD_SIZE-1:0] POLY       = 16'h100B
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              abort,
    mcpu_ram_bist_if.master        ram,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ADDR_WIDTH:0]    err_count,
    output logic [ADDR_WIDTH-1:0]  fail_addr
);

    localparam logic [WORD_SIZE-1:0]  c_seed    = (SEED == '0) ? {{(WORD_SIZE-1){1'b0}}, 1'b1} : SEED;
    localparam logic [ADDR_WIDTH-1:0] c_last    = '1;
    localparam logic [ADDR_WIDTH-1:0] c_cnt_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_err_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_CMP  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [WORD_SIZE-1:0]  r_lfsr;
    logic [ADDR_WIDTH:0]   r_err;
    logic [ADDR_WIDTH-1:0] r_fail;
    logic                  r_we;
    logic                  r_re;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_iaddr;
    logic [WORD_SIZE-1:0]  r_datawr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;

    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic [WORD_SIZE-1:0]  w_lfsr_nxt;
    logic [ADDR_WIDTH:0]   w_err_nxt;
    logic [ADDR_WIDTH-1:0] w_fail_nxt;
    logic                  w_we_nxt;
    logic                  w_re_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_iaddr_nxt;
    logic [WORD_SIZE-1:0]  w_datawr_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_pass_nxt;

    logic [WORD_SIZE-1:0]  w_lfsr_step;
    logic                  w_cnt_last;
    logic                  w_mismatch;

    // Galois step: shift left, fold the feedback mask in when the MSB falls out
    assign w_lfsr_step = {r_lfsr[WORD_SIZE-2:0], 1'b0} ^ (r_lfsr[WORD_SIZE-1] ? POLY : '0);
    assign w_cnt_last  = (r_cnt == c_last);
    assign w_mismatch  = (ram.datard != r_lfsr) || (ram.instrrd != r_lfsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lfsr_nxt   = r_lfsr;
        w_err_nxt    = r_err;
        w_fail_nxt   = r_fail;
        w_we_nxt     = 1'b0;
        w_re_nxt     = 1'b0;
        w_addr_nxt   = '0;
        w_iaddr_nxt  = '0;
        w_datawr_nxt = '0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_pass_nxt   = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_lfsr_nxt  = c_seed;
            w_err_nxt   = '0;
            w_fail_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_WRITE;
                        w_cnt_nxt   = '0;
                        w_lfsr_nxt  = c_seed;
                        w_err_nxt   = '0;
                        w_fail_nxt  = '0;
                    end else if (r_state == S_DONE) begin
                        w_done_nxt = 1'b1;
                        w_pass_nxt = (r_err == '0);
                    end
                end
                S_WRITE: begin
                    w_we_nxt     = 1'b1;
                    w_addr_nxt   = r_cnt;
                    w_datawr_nxt = r_lfsr;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = r_cnt + c_cnt_one;
                    w_lfsr_nxt   = w_lfsr_step;
                    if (w_cnt_last) begin
                        // read-back replays the sequence from the seed
                        w_state_nxt = S_RD_ADDR;
                        w_cnt_nxt   = '0;
                        w_lfsr_nxt  = c_seed;
                    end
                end
                S_RD_ADDR: begin
                    w_re_nxt    = 1'b1;
                    w_addr_nxt  = r_cnt;
                    w_iaddr_nxt = r_cnt;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RD_CMP;
                end
                S_RD_CMP: begin
                    w_re_nxt    = 1'b1;
                    w_addr_nxt  = r_cnt;
                    w_iaddr_nxt = r_cnt;
                    w_busy_nxt  = 1'b1;
                    if (w_mismatch) begin
                        w_err_nxt = r_err + c_err_one;
                        if (r_err == '0) begin
                            w_fail_nxt = r_cnt;
                        end
                    end
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                    w_lfsr_nxt  = w_lfsr_step;
                    w_state_nxt = w_cnt_last ? S_DONE : S_RD_ADDR;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_lfsr   <= c_seed;
            r_err    <= '0;
            r_fail   <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_addr   <= '0;
            r_iaddr  <= '0;
            r_datawr <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_err    <= w_err_nxt;
            r_fail   <= w_fail_nxt;
            r_we     <= w_we_nxt;
            r_re     <= w_re_nxt;
            r_addr   <= w_addr_nxt;
            r_iaddr  <= w_iaddr_nxt;
            r_datawr <= w_datawr_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    assign ram.we        = r_we;
    assign ram.re        = r_re;
    assign ram.addr      = r_addr;
    assign ram.instraddr = r_iaddr;
    assign ram.datawr    = r_datawr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign fail_addr     = r_fail;

endmodule
`default_nettype wire

// File: doc/mcpu_ram_bist.md
# mcpu_ram_bist

Sequential initiator for the MCPU RAM controller's write, data-read and instruction-read ports. On a start pulse it fills every RAM address with an LFSR-generated word. It then reads each address back through both the data and instruction ports, compares against the regenerated sequence, and reports pass/fail, an error count and the first failing address. It sits between the MCPU control logic (or a bench) and the RAM controller, and owns that controller's `we`/`re`/`addr`/`datawr`/`instraddr` inputs while active.

## Interface
Parameters:
- WORD_SIZE, 16, data/instruction word width; must match the RAM controller.
- ADDR_WIDTH, 8, address width; RAM_SIZE = 1<<ADDR_WIDTH.
- SEED, 16'hACE1, LFSR start value; 0 is replaced by 1.
- POLY, 16'h100B, Galois LFSR feedback mask (WORD_SIZE bits).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; ignored unless state is IDLE or DONE.
- abort  in  1  return to IDLE on the next edge from any state.
- we  out  1  RAM write enable.
- re  out  1  RAM read enable.
- addr  out  ADDR_WIDTH  data-port address.
- datawr  out  WORD_SIZE  write data.
- instraddr  out  ADDR_WIDTH  instruction-port address.
- datard  in  WORD_SIZE  data-port read word.
- instrrd  in  WORD_SIZE  instruction-port read word.
- busy  out  1  high in WRITE/RD_ADDR/RD_CMP.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  ADDR_WIDTH+1  number of failing addresses.
- fail_addr  out  ADDR_WIDTH  first failing address; 0 if none.

## Operation
- LFSR step: next = {lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? POLY : 0).
  - With defaults: ACE1 -> 49C9 -> 9392.
- All outputs are registered. Reset values: every output 0, state IDLE, lfsr=SEED, cnt=0.
- IDLE: we=re=0. On start -> WRITE with cnt=0, lfsr=SEED, err_count=0, fail_addr=0.
- WRITE: each cycle we=1, addr=cnt, datawr=lfsr; lfsr and cnt advance.
  - At cnt==RAM_SIZE-1 -> RD_ADDR with cnt=0 (wrap), lfsr=SEED, we=0.
- RD_ADDR: re=1, addr=instraddr=cnt.
  - The expected word is the current lfsr -> RD_CMP.
- RD_CMP: re=1 with addresses held; sample datard and instrrd.
  - Address fails if datard!=lfsr or instrrd!=lfsr. Both ports wrong counts once.
  - On the first failure, latch fail_addr=cnt; err_count increments.
  - err_count cannot overflow: maximum RAM_SIZE fits ADDR_WIDTH+1.
  - Then lfsr and cnt advance. If cnt==RAM_SIZE-1 -> DONE, else -> RD_ADDR.
- DONE: we=re=0; done=1; pass, err_count and fail_addr held. start restarts (as IDLE).
- abort: -> IDLE next edge; we/re drop that edge; err_count/fail_addr cleared; pass=0.
- abort wins over start in the same cycle.
- start while busy: ignored.
- rst_n low at any time: immediate return to reset values, including mid-WRITE (we drops asynchronously).
- instraddr is 0 outside read states; datawr is 0 outside WRITE.

## Timing
- start sampled at edge 0 -> first write (we=1, addr=0) visible after edge 1.
- Write phase: RAM_SIZE cycles. Read phase: 2*RAM_SIZE cycles.
- done rises after edge 3*RAM_SIZE+1 from start (769 cycles with defaults).
- The RAM controller writes on the edge ending a we=1 cycle.
- Read data must be valid one full cycle after addresses are driven, since compare happens in RD_CMP.
- busy and done are never high together. done stays high until start, abort or reset.

## Test plan
- Fault-free RAM model, defaults, start pulse:
  - writes to addr 0,1,2 carry ACE1, 49C9, 9392.
  - done at cycle 769, pass=1, err_count=0, fail_addr=0.
- Data-port bit 3 stuck-at-0 on address 5 only -> pass=0, err_count=1, fail_addr=5.
- instrrd forced to ~expected for addresses 10..12 and datard also wrong at 11 -> err_count=3, fail_addr=10.
- abort asserted at write address 40 -> next cycle we=0, busy=0, IDLE.
  - A new start rewrites from addr 0 with ACE1.
- rst_n pulsed low mid-read (address 100) -> all outputs 0 immediately.
  - After release, start produces a full clean run with pass=1.
- start held high during busy and in DONE -> no effect mid-run; a restart from DONE clears err_count and re-runs to done.
